mt_predictor: RTL and testbench
===============================

Name: mt_predictor

Overview:
Companion to the MT19937 generator. It consumes 624 consecutive tempered 32-bit outputs of a generator, untempers each one to rebuild the full 624-word state, and then predicts the generator's subsequent outputs bit-exactly. Used as a self-checking sink and a state-recovery engine next to the generator on the same clock domain.

Parameters:
N, 624, state length in words
M, 397, twist offset
CW, 10, counter/index width; must satisfy 2^CW > N

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
in_valid  in  1  in_data carries an observed generator output
in_data  in  32  tempered generator output
in_ready  out  1  word accepted on in_valid&in_ready
locked  out  1  624 words collected; prediction enabled
count  out  CW  number of words collected so far (0..N)
start  in  1  pulse: request next predicted output
valid  out  1  rand_out holds a fresh prediction
rand_out  out  32  predicted output

Behaviour:
- Reset values: in_ready=1, locked=0, count=0, valid=0, rand_out=0, idx=N. State RAM contents are don't-care.
- COLLECT phase, per word:
  - accept cycle: latch y=in_data; in_ready drops the next cycle.
  - 8 compute cycles, one step each:
    - L inverse: x=y^(y>>18).
    - T inverse: x=x^((x<<15)&C).
    - S inverse: z=x, then 4 iterations of z=x^((z<<7)&B).
    - U inverse: w=z, then 2 iterations of w=z^(w>>11).
  - last compute cycle: write mt[count]=w, count+1, in_ready=1 again.
  - Throughput: 1 word per 9 cycles.
- in_valid while in_ready=0 is ignored; the word is not captured.
- Lock: the write of word N-1 sets locked=1, count stays N, in_ready=0 permanently until rst.
- start while locked=0 is ignored; valid stays 0.
- PREDICT phase, generator-compatible handshake:
  - start sets valid=0 in the next cycle.
  - If idx>=N: TWIST runs for N cycles, i=0..N-1 in place, with the standard MT19937 recurrence mt[i]=mt[(i+M)%N]^(((mt[i]&UPPER)|(mt[(i+1)%N]&LOWER))>>1)^(lsb?A:0). Then idx=0.
  - TEMPER takes 5 cycles (load mt[idx], U, S, T, L). The last cycle drives rand_out, sets valid=1 and idx+1.
  - Latency from start to valid: 6 cycles normally; 630 cycles when a twist is required, including the first prediction after lock.
- valid and rand_out hold until the next start.
- start while busy (twisting or tempering) is ignored; the current request completes.
- rst mid-operation returns to COLLECT with count=0; all previously collected words are discarded.
- Arithmetic: all 32-bit unsigned; shifts logical; indices wrap mod N via compare, not the % operator in hardware.

Decomposition:
- Package mt19937_pkg: N, M, UPPER_MASK 0x80000000, LOWER_MASK 0x7FFFFFFF, A 0x9908B0DF, U 11, S 7, B 0x9D2C5680, T 15, C 0xEFC60000, L 18, and the FSM state enum (COLLECT, UNTEMPER, LOCKED_IDLE, TWIST, TEMPER).
- One sub-module, mt_untemper: the iterative 8-step inverse with start/done handshake, shared as the golden inverse for benches.
- Twist and temper logic stay in the top level alongside the state RAM.

Test Plan:
- Feed 624 outputs of the generator with SEED=5489 (first 3499211612, second 581869302, third 3890346734) at the max rate -> locked rises 9 cycles after the last accept. Then 4 start pulses -> rand_out equals generator outputs 625..628 bit-exact; first valid 630 cycles after start, later ones 6 cycles.
- mt_untemper standalone on temper(x) for x=0x00000000, 0xFFFFFFFF, 0x80000001, 0x12345678 -> returns x exactly, done 8 cycles after start.
- in_valid held high continuously -> exactly one word accepted per 9 cycles; count=624 after 5616 cycles; words presented while in_ready=0 are dropped.
- start pulsed before lock (count=100) -> valid stays 0, count unchanged. start pulsed during the twist -> no restart; single valid at cycle 630.
- rst asserted at count=300, then a full 624-word restream of the seed-5489 sequence -> predictions still match the generator; count restarts at 0.
- 624 further predictions after lock -> second twist triggered at prediction 625; outputs match the generator's words 1249 onward.

Source files
------------

// File: rtl/mt19937_pkg.sv
// Shared MT19937 constants and the predictor's FSM state type.
// Both the untemper sub-module and the predictor top level import this package.
package mt19937_pkg;

    localparam int N  = 624;
    localparam int M  = 397;
    localparam int CW = 10;

    localparam logic [31:0] UPPER_MASK = 32'h8000_0000;
    localparam logic [31:0] LOWER_MASK = 32'h7FFF_FFFF;
    localparam logic [31:0] A          = 32'h9908_B0DF;
    localparam logic [31:0] B          = 32'h9D2C_5680;
    localparam logic [31:0] C          = 32'hEFC6_0000;

    localparam int U = 11;
    localparam int S = 7;
    localparam int T = 15;
    localparam int L = 18;

    typedef enum logic [2:0] {
        COLLECT,
        UNTEMPER,
        LOCKED_IDLE,
        TWIST,
        TEMPER
    } state_e;

endpackage

// File: rtl/mt_predictor_if.sv
// Observation stream plus prediction handshake between an MT19937 predictor and its user.
// The master side feeds observed words and requests predictions; the slave side is the predictor.
interface mt_predictor_if;
    import mt19937_pkg::*;

    logic          in_valid;
    logic [31:0]   in_data;
    logic          in_ready;
    logic          locked;
    logic [CW-1:0] count;
    logic          start;
    logic          valid;
    logic [31:0]   rand_out;

    modport master (
        output in_valid, in_data, start,
        input  in_ready, locked, count, valid, rand_out
    );

    modport slave (
        input  in_valid, in_data, start,
        output in_ready, locked, count, valid, rand_out
    );

endinterface

// File: rtl/mt_untemper.sv
// Iterative MT19937 tempering inverse: one step per cycle, eight cycles per word.
// done is high during the last step, with w_out carrying the final untempered word.
module mt_untemper
    import mt19937_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] y_in,
    output logic        done,
    output logic [31:0] w_out
);

    logic        busy_q, busy_d;
    logic [2:0]  step_q, step_d;
    logic [31:0] base_q, base_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] res;

    // base holds the fixed operand of the current inverse, acc the running fix-point iterate
    always_comb begin
        res = acc_q;
        case (step_q)
            3'd0:                res = base_q ^ (base_q >> L);
            3'd1:                res = base_q ^ ((base_q << T) & C);
            3'd2, 3'd3, 3'd4,
            3'd5:                res = base_q ^ ((acc_q << S) & B);
            default:             res = base_q ^ (acc_q >> U);
        endcase
    end

    always_comb begin
        busy_d = busy_q;
        step_d = step_q;
        base_d = base_q;
        acc_d  = acc_q;
        if (start) begin
            busy_d = 1'b1;
            step_d = 3'd0;
            base_d = y_in;
            acc_d  = y_in;
        end else if (busy_q) begin
            step_d = step_q + 3'd1;
            acc_d  = res;
            if (step_q == 3'd0 || step_q == 3'd1 || step_q == 3'd5) begin
                base_d = res;
            end
            if (step_q == 3'd7) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            step_q <= 3'd0;
            base_q <= 32'h0;
            acc_q  <= 32'h0;
        end else begin
            busy_q <= busy_d;
            step_q <= step_d;
            base_q <= base_d;
            acc_q  <= acc_d;
        end
    end

    assign done  = busy_q && (step_q == 3'd7);
    assign w_out = res;

endmodule

// File: rtl/mt_predictor.sv
// MT19937 state recovery: untempers 624 observed words into the state RAM, then
// replays the generator's twist and temper to predict its subsequent outputs.
module mt_predictor
    import mt19937_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mt_predictor_if.slave bus
);

    state_e        state_q, state_d;
    logic          in_ready_q, in_ready_d;
    logic          locked_q, locked_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid_q, valid_d;
    logic [31:0]   rand_out_q, rand_out_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [CW-1:0] ctr_q, ctr_d;
    logic [31:0]   tmp_q, tmp_d;

    logic [31:0]   mt_ram [0:N-1];
    logic          wr_en;
    logic [CW-1:0] wr_addr;
    logic [31:0]   wr_data;

    logic          accept;
    logic          ut_done;
    logic [31:0]   ut_w;
    logic [CW-1:0] next_i;
    logic [CW-1:0] off_i;
    logic [31:0]   y_mix;
    logic [31:0]   twisted;

    assign accept = in_ready_q && bus.in_valid;

    mt_untemper u_untemper (
        .clk   (clk),
        .rst   (rst),
        .start (accept),
        .y_in  (bus.in_data),
        .done  (ut_done),
        .w_out (ut_w)
    );

    // In-place twist: neighbours past the wrap point are already updated, as in the reference generator
    always_comb begin
        next_i  = (ctr_q == CW'(N - 1)) ? '0 : ctr_q + 1'b1;
        off_i   = (ctr_q >= CW'(N - M)) ? ctr_q - CW'(N - M) : ctr_q + CW'(M);
        y_mix   = (mt_ram[ctr_q] & UPPER_MASK) | (mt_ram[next_i] & LOWER_MASK);
        twisted = mt_ram[off_i] ^ (y_mix >> 1) ^ (y_mix[0] ? A : 32'h0);
    end

    always_comb begin
        state_d    = state_q;
        in_ready_d = in_ready_q;
        locked_d   = locked_q;
        count_d    = count_q;
        valid_d    = valid_q;
        rand_out_d = rand_out_q;
        idx_d      = idx_q;
        ctr_d      = ctr_q;
        tmp_d      = tmp_q;
        wr_en      = 1'b0;
        wr_addr    = count_q;
        wr_data    = ut_w;
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    in_ready_d = 1'b0;
                    state_d    = UNTEMPER;
                end
            end
            UNTEMPER: begin
                if (ut_done) begin
                    wr_en   = 1'b1;
                    count_d = count_q + 1'b1;
                    if (count_q == CW'(N - 1)) begin
                        locked_d = 1'b1;
                        state_d  = LOCKED_IDLE;
                    end else begin
                        in_ready_d = 1'b1;
                        state_d    = COLLECT;
                    end
                end
            end
            LOCKED_IDLE: begin
                if (bus.start) begin
                    valid_d = 1'b0;
                    ctr_d   = '0;
                    state_d = (idx_q >= CW'(N)) ? TWIST : TEMPER;
                end
            end
            TWIST: begin
                wr_en   = 1'b1;
                wr_addr = ctr_q;
                wr_data = twisted;
                ctr_d   = next_i;
                if (ctr_q == CW'(N - 1)) begin
                    idx_d   = '0;
                    state_d = TEMPER;
                end
            end
            TEMPER: begin
                ctr_d = ctr_q + 1'b1;
                case (ctr_q[2:0])
                    3'd0:    tmp_d = mt_ram[idx_q];
                    3'd1:    tmp_d = tmp_q ^ (tmp_q >> U);
                    3'd2:    tmp_d = tmp_q ^ ((tmp_q << S) & B);
                    3'd3:    tmp_d = tmp_q ^ ((tmp_q << T) & C);
                    default: begin
                        rand_out_d = tmp_q ^ (tmp_q >> L);
                        valid_d    = 1'b1;
                        idx_d      = idx_q + 1'b1;
                        state_d    = LOCKED_IDLE;
                    end
                endcase
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= COLLECT;
            in_ready_q <= 1'b1;
            locked_q   <= 1'b0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            rand_out_q <= 32'h0;
            idx_q      <= CW'(N);
            ctr_q      <= '0;
            tmp_q      <= 32'h0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            locked_q   <= locked_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            rand_out_q <= rand_out_d;
            idx_q      <= idx_d;
            ctr_q      <= ctr_d;
            tmp_q      <= tmp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mt_ram[wr_addr] <= wr_data;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.locked   = locked_q;
    assign bus.count    = count_q;
    assign bus.valid    = valid_q;
    assign bus.rand_out = rand_out_q;

endmodule

// File: tb/tb_mt_predictor.sv
// Bench for mt_predictor: a software MT19937 generator supplies the observed stream and
// the expected predictions; mt_untemper is also exercised on its own.
module tb_mt_predictor;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mt_predictor_if bus ();

    mt_predictor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic        ut_start;
    logic [31:0] ut_y;
    logic        ut_done;
    logic [31:0] ut_w;

    mt_untemper ut (
        .clk   (clk),
        .rst   (rst),
        .start (ut_start),
        .y_in  (ut_y),
        .done  (ut_done),
        .w_out (ut_w)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] gm [624];
    int          gidx;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    function automatic logic [31:0] temper(input logic [31:0] v);
        logic [31:0] y;
        y = v;
        y = y ^ (y >> 11);
        y = y ^ ((y << 7) & 32'h9D2C5680);
        y = y ^ ((y << 15) & 32'hEFC60000);
        y = y ^ (y >> 18);
        return y;
    endfunction

    task automatic gen_seed(input logic [31:0] s);
        gm[0] = s;
        for (int i = 1; i < 624; i++) begin
            gm[i] = 32'd1812433253 * (gm[i-1] ^ (gm[i-1] >> 30)) + 32'(i);
        end
        gidx = 624;
    endtask

    task automatic gen_next(output logic [31:0] r);
        logic [31:0] y;
        if (gidx >= 624) begin
            for (int i = 0; i < 624; i++) begin
                y = (gm[i] & 32'h80000000) | (gm[(i + 1) % 624] & 32'h7FFFFFFF);
                gm[i] = gm[(i + 397) % 624] ^ (y >> 1) ^ (y[0] ? 32'h9908B0DF : 32'h0);
            end
            gidx = 0;
        end
        r = temper(gm[gidx]);
        gidx++;
    endtask

    // One start pulse; latency counted in cycles until valid, optionally re-poking start mid-wait
    task automatic predict_one(input string tag, input int exp_lat, input bit poke);
        logic [31:0] exp;
        int n;
        gen_next(exp);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        check_output({tag, "_valid_drop"}, 32'(bus.valid), 32'd0);
        while (!bus.valid && n < 700) begin
            bus.start = (poke && n == 100);
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        check_output({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check_output({tag, "_data"}, bus.rand_out, exp);
        repeat ($urandom_range(1, 3)) @(negedge clk);
        check_output({tag, "_hold_valid"}, 32'(bus.valid), 32'd1);
        check_output({tag, "_hold_data"}, bus.rand_out, exp);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] w;
        logic [31:0] ut_vals [4];
        logic [31:0] first_words [3];
        int n;
        int k;
        int cyc;
        bit poked;
        bit gate;

        ut_vals     = '{32'h00000000, 32'hFFFFFFFF, 32'h80000001, 32'h12345678};
        first_words = '{32'd3499211612, 32'd581869302, 32'd3890346734};

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 32'h0;
        bus.start    = 1'b0;
        ut_start     = 1'b0;
        ut_y         = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check_output("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_output("rst_locked", 32'(bus.locked), 32'd0);
        check_output("rst_count", 32'(bus.count), 32'd0);
        check_output("rst_valid", 32'(bus.valid), 32'd0);
        check_output("rst_rand_out", bus.rand_out, 32'd0);

        $display("[TB] untemper standalone");
        for (int v = 0; v < 4; v++) begin
            ut_y     = temper(ut_vals[v]);
            ut_start = 1'b1;
            @(negedge clk);
            ut_start = 1'b0;
            n = 1;
            while (!ut_done && n < 20) begin
                @(negedge clk);
                n++;
            end
            check_output("ut_latency", 32'(n), 32'd8);
            check_output("ut_value", ut_w, ut_vals[v]);
            @(negedge clk);
        end

        $display("[TB] max-rate stream with junk between accepts");
        gen_seed(32'd5489);
        for (int c = 0; c < 5616; c++) begin
            bus.in_valid = 1'b1;
            if (c % 9 == 0) begin
                gen_next(w);
                bus.in_data = w;
                if (c < 27) check_output("model_first_words", w, first_words[c / 9]);
                check_output("stream_count", 32'(bus.count), 32'(c / 9));
            end else begin
                bus.in_data = $urandom;
            end
            check_output("stream_in_ready", 32'(bus.in_ready), 32'(c % 9 == 0));
            if (c == 5615) check_output("stream_locked_early", 32'(bus.locked), 32'd0);
            @(negedge clk);
        end
        check_output("stream_locked", 32'(bus.locked), 32'd1);
        check_output("stream_count_full", 32'(bus.count), 32'd624);
        for (int c = 0; c < 20; c++) begin
            bus.in_data = $urandom;
            check_output("locked_in_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check_output("locked_count_stays", 32'(bus.count), 32'd624);

        $display("[TB] predictions across two twists");
        for (int p = 0; p < 625; p++) begin
            predict_one("pred", (p == 0 || p == 624) ? 630 : 6, p == 0);
        end

        $display("[TB] early start, reset mid-collection, restream");
        poked = 1'b0;
        cyc   = 0;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("rst2_count", 32'(bus.count), 32'd0);
        check_output("rst2_locked", 32'(bus.locked), 32'd0);
        check_output("rst2_valid", 32'(bus.valid), 32'd0);
        while (bus.count != 10'd300 && cyc < 10000) begin
            if (bus.count == 10'd100 && !poked) begin
                poked        = 1'b1;
                bus.in_valid = 1'b0;
                bus.start    = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
                repeat (10) @(negedge clk);
                check_output("early_start_valid", 32'(bus.valid), 32'd0);
                check_output("early_start_count", 32'(bus.count), 32'd100);
            end
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_data  = $urandom;
            @(negedge clk);
            cyc++;
        end
        check_output("reach_300", 32'(bus.count), 32'd300);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("rst3_count", 32'(bus.count), 32'd0);
        check_output("rst3_in_ready", 32'(bus.in_ready), 32'd1);

        gen_seed(32'd5489);
        gen_next(w);
        k   = 0;
        cyc = 0;
        while (k < 624 && cyc < 20000) begin
            gate = ($urandom_range(0, 2) != 0);
            bus.in_valid = gate;
            bus.in_data  = gate ? w : $urandom;
            if (gate && bus.in_ready) begin
                k++;
                if (k < 624) gen_next(w);
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        check_output("restream_words", 32'(k), 32'd624);
        n = 0;
        while (!bus.locked && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_output("restream_locked", 32'(bus.locked), 32'd1);
        check_output("restream_count", 32'(bus.count), 32'd624);
        for (int p = 0; p < 4; p++) begin
            predict_one("repred", (p == 0) ? 630 : 6, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
